// File: rtl/ln_1to2_rtr.sv
// 1-to-2 message router for the 4-phase req/ack link fabric.
// Each output owns a one-message holding buffer so the input can retire early.

// Per-output handshake FSM: presents a full buffer, frees it on ack.
module ln_1to2_rtr_out (
  input  logic clk,
  input  logic rst_n,
  input  logic full,
  input  logic ack,
  output logic req,
  output logic clr
);
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_REL} out_st_t;
  out_st_t st, nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= OUT_IDLE;
    else        st <= nxt;

  always_comb begin
    nxt = st;
    clr = 1'b0;
    case (st)
      OUT_IDLE: if (full && !ack) nxt = OUT_REQ;
      OUT_REQ:  if (ack) begin nxt = OUT_REL; clr = 1'b1; end
      OUT_REL:  if (!ack) nxt = OUT_IDLE;
      default:  nxt = OUT_IDLE;
    endcase
  end

  assign req = (st == OUT_REQ);
endmodule

// Operator codes: 0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE (addr OP ref).
module ln_1to2_rtr #(
  parameter int ASZ       = 8,
  parameter int DSZ       = 8,
  parameter int OPER_1    = 2,
  parameter int REF_VAL_1 = 0,
  parameter bit IS_RANGE  = 1'b0,
  parameter int OPER_2    = 2,
  parameter int REF_VAL_2 = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i_addr,
  input  logic [DSZ-1:0] i_dat,
  input  logic           i_req,
  output logic           o_ack,
  output logic [ASZ-1:0] o_0_addr,
  output logic [DSZ-1:0] o_0_dat,
  output logic           o_0_req,
  input  logic           i_0_ack,
  output logic [ASZ-1:0] o_1_addr,
  output logic [DSZ-1:0] o_1_dat,
  output logic           o_1_req,
  input  logic           i_1_ack
);
  localparam int NOUT  = 2;
  localparam int EQ_OP = 0, NE_OP = 1, GT_OP = 2, GE_OP = 3, LT_OP = 4, LE_OP = 5;

  typedef enum logic {IN_IDLE, IN_ACK} in_st_t;

  function automatic logic cmp(input int op, input logic [ASZ-1:0] a, input int rv);
    logic [ASZ-1:0] r;
    r = ASZ'(rv);
    case (op)
      EQ_OP:   return a == r;
      NE_OP:   return a != r;
      GT_OP:   return a >  r;
      GE_OP:   return a >= r;
      LT_OP:   return a <  r;
      LE_OP:   return a <= r;
      default: return 1'b0;
    endcase
  endfunction

  in_st_t                    in_st, in_nxt;
  logic                      sel, tgt;
  logic [NOUT-1:0]           full, set, clr, req;
  logic [NOUT-1:0][ASZ-1:0]  baddr;
  logic [NOUT-1:0][DSZ-1:0]  bdat;

  // sel true means output 0, so the buffer index is its inverse
  assign sel = cmp(OPER_1, i_addr, REF_VAL_1) && (!IS_RANGE || cmp(OPER_2, i_addr, REF_VAL_2));
  assign tgt = ~sel;

  always_comb begin
    in_nxt = in_st;
    set    = '0;
    case (in_st)
      IN_IDLE: if (i_req && !full[tgt]) begin in_nxt = IN_ACK; set[tgt] = 1'b1; end
      IN_ACK:  if (!i_req) in_nxt = IN_IDLE;
      default: in_nxt = IN_IDLE;
    endcase
  end

  // set and clr never hit the same buffer on one edge: set needs empty, clr needs full
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      in_st <= IN_IDLE;
      full  <= '0;
      baddr <= '0;
      bdat  <= '0;
    end else begin
      in_st <= in_nxt;
      full  <= (full | set) & ~clr;
      for (int k = 0; k < NOUT; k++)
        if (set[k]) begin
          baddr[k] <= i_addr;
          bdat[k]  <= i_dat;
        end
    end

  ln_1to2_rtr_out u_out [NOUT-1:0] (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .full  (full),
    .ack   ({i_1_ack, i_0_ack}),
    .req   (req),
    .clr   (clr)
  );

  assign o_ack    = (in_st == IN_ACK);
  assign o_0_req  = req[0];
  assign o_1_req  = req[1];
  assign o_0_addr = baddr[0];
  assign o_0_dat  = bdat[0];
  assign o_1_addr = baddr[1];
  assign o_1_dat  = bdat[1];
endmodule
